coherence_ctrl: RTL and testbench
=================================

# coherence_ctrl

Bus and coherence controller shared by two cores' dcaches and icaches in front of the single RAM port. It arbitrates block transfers and sequences snoop/invalidate handshakes between the two dcaches. A dirty peer block goes cache-to-cache and is written through to RAM in the same beat. Instruction fetches are served when no dcache request is pending.

## Interface
- CPUS, 2, number of cores; only 2 is supported; all per-core ports are [CPUS-1:0] arrays, index = core.
- CLK  in  1  clock; one clock.
- RST  in  1  reset; synchronous and active-high.
- dREN, dWEN, cctrans, ccwrite  in  [1:0]  dcache request/coherence strobes.
- daddr, dstore  in  [1:0][31:0]  dcache word address / store data.
- dwait  out  [1:0]  low for exactly the cycle a dcache word completes.
- dload  out  [1:0][31:0]  load data to each dcache.
- ccwait, ccinv  out  [1:0]  snoop request / invalidate to a dcache.
- ccsnoopaddr  out  [1:0][31:0]  snoop address.
- iREN  in  [1:0]  icache read request; iaddr  in  [1:0][31:0].
- iwait  out  [1:0]  low for exactly the cycle a fetch completes; iload  out  [1:0][31:0].
- ramREN, ramWEN  out  1; ramaddr, ramstore  out  32; ramload  in  32.
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR; only ACCESS completes a beat.

## Operation
- Registers: state, g (granted core, 1 bit), last (round-robin pointer), snp_addr (32). p = ~g is the peer.
- Default outputs every cycle: dwait=2'b11, iwait=2'b11, all cc*/ram strobes 0, loads/addresses 0.
- IDLE: a core is requesting if dREN|dWEN|cctrans. Both requesting -> g=~last, last<=g. Priority within a core: dWEN -> WB1; dREN -> SNOOP (snp_addr<=daddr[g]); cctrans alone (write-hit upgrade) -> INV (snp_addr<=daddr[g]). With no dcache request, iREN uses the same round-robin -> IFETCH.
- WB1/WB2: ramWEN=1, ramaddr/ramstore from core g. On ACCESS, dwait[g]=0, advance WB1->WB2->IDLE.
- SNOOP: ccwait[p]=1, ccsnoopaddr[p]=snp_addr, ccinv[p]=0. Wait for cctrans[p]. When it is seen: ccwrite[p]=1 -> C2C1, else -> LD1.
- C2C1/C2C2: peer drives dWEN with its block words. ramWEN=1, ramaddr=daddr[p], ramstore=dstore[p], dload[g]=dstore[p]. On ACCESS, dwait[p]=0 and dwait[g]=0 in the same cycle; C2C1->C2C2->IDLE.
- LD1/LD2: ramREN=1, ramaddr=daddr[g], dload[g]=ramload. On ACCESS, dwait[g]=0; LD1->LD2->IDLE.
- INV: ccwait[p]=1, ccinv[p]=1, ccsnoopaddr[p]=snp_addr until cctrans[p] is seen, then IDLE. The requester gets no dwait pulse.
- IFETCH: ramREN=1, ramaddr=iaddr[g], iload[g]=ramload. On ACCESS, iwait[g]=0 -> IDLE.
- ERROR and BUSY are treated like FREE: the state holds and the strobes stay asserted.

## Timing
- All outputs are combinational from registered state plus inputs; transitions are registered.
- Arbitration: 1 cycle in IDLE, no RAM activity that cycle.
- Read miss, clean peer: IDLE(1) + SNOOP(>=2) + LD1 + LD2. With 1-cycle ACCESS RAM that is 5 cycles from request to second dwait pulse.
- Dirty peer: the same timing, with C2C1/C2C2 replacing LD1/LD2.
- RST mid-transaction: state=IDLE, last=0, g=0, snp_addr=0 next edge; all outputs return to default.
- Simultaneous dcache request from one core and iREN from the other: the dcache request wins; the icache waits.
- last toggles only on an actual dual-request grant; a single requester does not move it.

## Structure
- diaosi_types_pkg: CcState_t enum (IDLE, WB1, WB2, SNOOP, C2C1, C2C2, LD1, LD2, INV, IFETCH).
- cpu_types_pkg: ramstate_t and word_t.
- Sub-module rr_arb2: 2-requester round-robin grant with a registered pointer; instanced twice (dcache, icache) sharing the pointer update rule.

## Test plan
- Core0 dREN daddr=0x100, peer cctrans=1 ccwrite=0, RAM 1-cycle: ramREN on 0x100 then 0x104; dload[0] = RAM words; dwait[0] low exactly twice; state back to IDLE.
- Core1 dREN 0x200, core0 answers ccwrite=1 and then dWEN dstore=0xAAAA/0xBBBB: dload[1]=0xAAAA,0xBBBB; ramWEN at 0x200/0x204 with the same data; dwait[0] and dwait[1] low in the same cycles.
- Both cores dWEN in the same cycle after reset: core1 served first (last=0), then core0. Repeat: order alternates.
- Core0 cctrans alone at 0x300: ccwait[1]=ccinv[1]=1, ccsnoopaddr[1]=0x300 held until cctrans[1]; no ram strobes; no dwait pulse.
- iREN[0] at 0x40 with ramstate BUSY for 3 cycles then ACCESS: ramREN held 4 cycles; iwait[0] low one cycle; iload[0]=ramload.
- RST asserted during LD2: next cycle state=IDLE, all dwait/iwait=1, ramREN=0; a new request is accepted the following cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the RAM handshake state and the machine word.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// Coherence controller state encoding.
package diaosi_types_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    WB1    = 4'd1,
    WB2    = 4'd2,
    SNOOP  = 4'd3,
    C2C1   = 4'd4,
    C2C2   = 4'd5,
    LD1    = 4'd6,
    LD2    = 4'd7,
    INV    = 4'd8,
    IFETCH = 4'd9
  } CcState_t;

endpackage

// File: rtl/coherence_ctrl_if.sv
// Cache/RAM bus seen by the coherence controller; index of every per-core field = core.
interface coherence_ctrl_if #(parameter int CPUS = 2);

  logic [CPUS-1:0]                     dREN, dWEN, cctrans, ccwrite;
  cpu_types_pkg::word_t [CPUS-1:0]     daddr, dstore;
  logic [CPUS-1:0]                     dwait;
  cpu_types_pkg::word_t [CPUS-1:0]     dload;
  logic [CPUS-1:0]                     ccwait, ccinv;
  cpu_types_pkg::word_t [CPUS-1:0]     ccsnoopaddr;
  logic [CPUS-1:0]                     iREN, iwait;
  cpu_types_pkg::word_t [CPUS-1:0]     iaddr, iload;
  logic                                ramREN, ramWEN;
  cpu_types_pkg::word_t                ramaddr, ramstore, ramload;
  cpu_types_pkg::ramstate_t            ramstate;

  modport master (
    input  dREN, dWEN, cctrans, ccwrite, daddr, dstore, iREN, iaddr, ramload, ramstate,
    output dwait, dload, ccwait, ccinv, ccsnoopaddr, iwait, iload,
           ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output dREN, dWEN, cctrans, ccwrite, daddr, dstore, iREN, iaddr, ramload, ramstate,
    input  dwait, dload, ccwait, ccinv, ccsnoopaddr, iwait, iload,
           ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant. The pointer is loaded externally so that
// several instances can track one shared fairness history.
module rr_arb2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       ptr_ld,
  input  logic       ptr_val,
  output logic       gnt,
  output logic       dual
);

  logic last_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_reg <= 1'b0;
    end else if (ptr_ld) begin
      last_reg <= ptr_val;
    end
  end

  // A lone requester wins outright; a tie goes to the core not served last.
  assign dual = &req;
  assign gnt  = dual ? ~last_reg : req[1];

endmodule

// File: rtl/coherence_ctrl.sv
// Bus/coherence controller for two cores: arbitrates dcache/icache block
// transfers onto one RAM port and sequences snoop/invalidate with the peer dcache.
module coherence_ctrl
  import cpu_types_pkg::*, diaosi_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input logic              CLK,
  input logic              RST,
  coherence_ctrl_if.master ccif
);

  CcState_t        state_reg, state_next;
  logic            g_reg, g_next;
  word_t           snp_addr_reg, snp_addr_next;
  logic [CPUS-1:0] dreq;
  logic            p, access;
  logic            d_gnt, d_dual, i_gnt, i_dual;
  logic            ptr_ld, ptr_val;

  for (genvar gi = 0; gi < CPUS; gi++) begin : g_dreq
    assign dreq[gi] = ccif.dREN[gi] | ccif.dWEN[gi] | ccif.cctrans[gi];
  end

  assign p      = ~g_reg;
  assign access = (ccif.ramstate == ACCESS);

  rr_arb2 u_darb (.CLK(CLK), .RST(RST), .req(dreq), .ptr_ld(ptr_ld), .ptr_val(ptr_val),
                  .gnt(d_gnt), .dual(d_dual));
  rr_arb2 u_iarb (.CLK(CLK), .RST(RST), .req(ccif.iREN), .ptr_ld(ptr_ld), .ptr_val(ptr_val),
                  .gnt(i_gnt), .dual(i_dual));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      g_reg        <= 1'b0;
      snp_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      g_reg        <= g_next;
      snp_addr_reg <= snp_addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    g_next        = g_reg;
    snp_addr_next = snp_addr_reg;
    ptr_ld        = 1'b0;
    ptr_val       = 1'b0;
    case (state_reg)
      IDLE: begin
        // Any dcache traffic outranks instruction fetch.
        if (|dreq) begin
          g_next  = d_gnt;
          ptr_ld  = d_dual;
          ptr_val = d_gnt;
          if (ccif.dWEN[d_gnt]) begin
            state_next = WB1;
          end else begin
            snp_addr_next = ccif.daddr[d_gnt];
            state_next    = ccif.dREN[d_gnt] ? SNOOP : INV;
          end
        end else if (|ccif.iREN) begin
          g_next     = i_gnt;
          ptr_ld     = i_dual;
          ptr_val    = i_gnt;
          state_next = IFETCH;
        end
      end
      WB1:    if (access) state_next = WB2;
      WB2:    if (access) state_next = IDLE;
      SNOOP:  if (ccif.cctrans[p]) state_next = ccif.ccwrite[p] ? C2C1 : LD1;
      C2C1:   if (access) state_next = C2C2;
      C2C2:   if (access) state_next = IDLE;
      LD1:    if (access) state_next = LD2;
      LD2:    if (access) state_next = IDLE;
      INV:    if (ccif.cctrans[p]) state_next = IDLE;
      IFETCH: if (access) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ccif.dwait       = '1;
    ccif.iwait       = '1;
    ccif.ccwait      = '0;
    ccif.ccinv       = '0;
    ccif.ccsnoopaddr = '0;
    ccif.dload       = '0;
    ccif.iload       = '0;
    ccif.ramREN      = 1'b0;
    ccif.ramWEN      = 1'b0;
    ccif.ramaddr     = '0;
    ccif.ramstore    = '0;
    case (state_reg)
      WB1, WB2: begin
        ccif.ramWEN       = 1'b1;
        ccif.ramaddr      = ccif.daddr[g_reg];
        ccif.ramstore     = ccif.dstore[g_reg];
        ccif.dwait[g_reg] = ~access;
      end
      SNOOP: begin
        ccif.ccwait[p]      = 1'b1;
        ccif.ccsnoopaddr[p] = snp_addr_reg;
      end
      C2C1, C2C2: begin
        // Dirty peer block goes to the requester and to RAM in the same beat.
        ccif.ramWEN       = 1'b1;
        ccif.ramaddr      = ccif.daddr[p];
        ccif.ramstore     = ccif.dstore[p];
        ccif.dload[g_reg] = ccif.dstore[p];
        ccif.dwait[p]     = ~access;
        ccif.dwait[g_reg] = ~access;
      end
      LD1, LD2: begin
        ccif.ramREN       = 1'b1;
        ccif.ramaddr      = ccif.daddr[g_reg];
        ccif.dload[g_reg] = ccif.ramload;
        ccif.dwait[g_reg] = ~access;
      end
      INV: begin
        ccif.ccwait[p]      = 1'b1;
        ccif.ccinv[p]       = 1'b1;
        ccif.ccsnoopaddr[p] = snp_addr_reg;
      end
      IFETCH: begin
        ccif.ramREN       = 1'b1;
        ccif.ramaddr      = ccif.iaddr[g_reg];
        ccif.iload[g_reg] = ccif.ramload;
        ccif.iwait[g_reg] = ~access;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherence_ctrl.sv
// Directed bench for coherence_ctrl: stimulus queues expected beats, a negedge
// monitor compares every observable bus event against the queue head.
module tb_coherence_ctrl;
  import cpu_types_pkg::*;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] raddr;
    logic [31:0] rstore;
    logic [1:0]  dwait;
    logic [1:0]  iwait;
    logic [1:0]  ccwait;
    logic [1:0]  ccinv;
    logic [31:0] snp0;
    logic [31:0] snp1;
    logic [31:0] dl0;
    logic [31:0] dl1;
    logic [31:0] il0;
    logic [31:0] il1;
  } obs_t;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  obs_t  exp_q[$];
  string name_q[$];
  obs_t  act_o, exp_o;
  string exp_n;
  logic  evt;

  coherence_ctrl_if #(.CPUS(2)) bus ();

  coherence_ctrl #(.CPUS(2)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .ccif (bus.master)
  );

  always #5 CLK = ~CLK;

  // RAM returns a recognisable pattern derived from the address.
  assign bus.ramload = bus.ramaddr ^ 32'hDEAD0000;

  function automatic obs_t base();
    obs_t o;
    o       = '0;
    o.dwait = 2'b11;
    o.iwait = 2'b11;
    return o;
  endfunction

  task automatic push(input string n, input obs_t o);
    exp_q.push_back(o);
    name_q.push_back(n);
  endtask

  task automatic exp_ack(input string n, input logic [1:0] w, input logic [1:0] inv,
                         input logic [31:0] s0, input logic [31:0] s1);
    obs_t o = base();
    o.ccwait = w; o.ccinv = inv; o.snp0 = s0; o.snp1 = s1;
    push(n, o);
  endtask

  task automatic exp_ld(input string n, input logic c, input logic [31:0] a, input logic [31:0] d);
    obs_t o = base();
    o.ren = 1'b1; o.raddr = a; o.dwait = c ? 2'b01 : 2'b10;
    if (c) o.dl1 = d; else o.dl0 = d;
    push(n, o);
  endtask

  task automatic exp_wb(input string n, input logic c, input logic [31:0] a, input logic [31:0] d);
    obs_t o = base();
    o.wen = 1'b1; o.raddr = a; o.rstore = d; o.dwait = c ? 2'b01 : 2'b10;
    push(n, o);
  endtask

  task automatic exp_c2c(input string n, input logic g, input logic [31:0] a, input logic [31:0] d);
    obs_t o = base();
    o.wen = 1'b1; o.raddr = a; o.rstore = d; o.dwait = 2'b00;
    if (g) o.dl1 = d; else o.dl0 = d;
    push(n, o);
  endtask

  task automatic exp_if(input string n, input logic c, input logic [31:0] a, input logic [31:0] d);
    obs_t o = base();
    o.ren = 1'b1; o.raddr = a; o.iwait = c ? 2'b01 : 2'b10;
    if (c) o.il1 = d; else o.il0 = d;
    push(n, o);
  endtask

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, act, req);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Both cores write back at once; `first` is the core expected to win.
  task automatic both_wb(input logic first);
    logic s;
    s = ~first;
    step();
    bus.dWEN = 2'b11;
    bus.daddr[0] = 32'h500; bus.dstore[0] = 32'h5;
    bus.daddr[1] = 32'h600; bus.dstore[1] = 32'h6;
    if (first) begin
      exp_wb("dual_wb_c1_w0", 1'b1, 32'h600, 32'h6);
      exp_wb("dual_wb_c1_w1", 1'b1, 32'h604, 32'h66);
      exp_wb("dual_wb_c0_w0", 1'b0, 32'h500, 32'h5);
      exp_wb("dual_wb_c0_w1", 1'b0, 32'h504, 32'h55);
    end else begin
      exp_wb("dual_wb_c0_w0", 1'b0, 32'h500, 32'h5);
      exp_wb("dual_wb_c0_w1", 1'b0, 32'h504, 32'h55);
      exp_wb("dual_wb_c1_w0", 1'b1, 32'h600, 32'h6);
      exp_wb("dual_wb_c1_w1", 1'b1, 32'h604, 32'h66);
    end
    step();                                     // WB1 of first
    step();                                     // WB2 of first
    if (first) begin bus.daddr[1] = 32'h604; bus.dstore[1] = 32'h66; end
    else       begin bus.daddr[0] = 32'h504; bus.dstore[0] = 32'h55; end
    step();                                     // IDLE
    bus.dWEN[first] = 1'b0;
    step();                                     // WB1 of second
    step();                                     // WB2 of second
    if (s) begin bus.daddr[1] = 32'h604; bus.dstore[1] = 32'h66; end
    else   begin bus.daddr[0] = 32'h504; bus.dstore[0] = 32'h55; end
    step();                                     // IDLE
    bus.dWEN = 2'b00;
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      act_o.ren    = bus.ramREN;
      act_o.wen    = bus.ramWEN;
      act_o.raddr  = bus.ramaddr;
      act_o.rstore = bus.ramstore;
      act_o.dwait  = bus.dwait;
      act_o.iwait  = bus.iwait;
      act_o.ccwait = bus.ccwait;
      act_o.ccinv  = bus.ccinv;
      act_o.snp0   = bus.ccsnoopaddr[0];
      act_o.snp1   = bus.ccsnoopaddr[1];
      act_o.dl0    = bus.dload[0];
      act_o.dl1    = bus.dload[1];
      act_o.il0    = bus.iload[0];
      act_o.il1    = bus.iload[1];
      evt = ((bus.ramREN | bus.ramWEN) && bus.ramstate == ACCESS) ||
            (bus.dwait != 2'b11) || (bus.iwait != 2'b11) || (|(bus.ccwait & bus.cctrans));
      if (evt) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event got=%h", act_o);
        end else begin
          exp_o = exp_q.pop_front();
          exp_n = name_q.pop_front();
          if (act_o !== exp_o) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", exp_n, act_o, exp_o);
          end
        end
      end
    end
  end

  initial begin
    RST = 1'b1;
    bus.dREN = '0; bus.dWEN = '0; bus.cctrans = '0; bus.ccwrite = '0;
    bus.daddr = '0; bus.dstore = '0; bus.iREN = '0; bus.iaddr = '0;
    bus.ramstate = ACCESS;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("rst_dwait", 64'(bus.dwait), 64'h3);
    check("rst_iwait", 64'(bus.iwait), 64'h3);
    check("rst_ram_strobes", 64'({bus.ramREN, bus.ramWEN}), 64'h0);
    check("rst_ccwait", 64'(bus.ccwait), 64'h0);

    // Core0 read miss, clean peer.
    step();
    bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h100;
    exp_ack("rd_clean_ack", 2'b10, 2'b00, 32'h0, 32'h100);
    exp_ld("rd_clean_w0", 1'b0, 32'h100, 32'hDEAD0100);
    exp_ld("rd_clean_w1", 1'b0, 32'h104, 32'hDEAD0104);
    @(negedge CLK);
    check("arb_no_ram", 64'({bus.ramREN, bus.ramWEN}), 64'h0);
    step();                                     // SNOOP, no answer yet
    step(); bus.cctrans[1] = 1'b1;              // SNOOP answered
    step(); bus.cctrans[1] = 1'b0;              // LD1
    step(); bus.daddr[0] = 32'h104;             // LD2
    step(); bus.dREN[0] = 1'b0;                 // IDLE
    @(negedge CLK);
    check("rd_clean_idle_ren", 64'(bus.ramREN), 64'h0);

    // Core1 read miss, dirty peer forwards its block.
    step();
    bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h200;
    exp_ack("rd_dirty_ack", 2'b01, 2'b00, 32'h200, 32'h0);
    exp_c2c("c2c_w0", 1'b1, 32'h200, 32'hAAAA);
    exp_c2c("c2c_w1", 1'b1, 32'h204, 32'hBBBB);
    step();
    step(); bus.cctrans[0] = 1'b1; bus.ccwrite[0] = 1'b1;
    step(); bus.cctrans[0] = 1'b0; bus.ccwrite[0] = 1'b0;
            bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h200; bus.dstore[0] = 32'hAAAA;
    step(); bus.daddr[0] = 32'h204; bus.dstore[0] = 32'hBBBB; bus.daddr[1] = 32'h204;
    step(); bus.dWEN[0] = 1'b0; bus.dREN[1] = 1'b0;

    // Simultaneous write-backs alternate winners.
    both_wb(1'b1);
    both_wb(1'b0);

    // Upgrade invalidate, held until the peer acknowledges.
    step();
    bus.cctrans[0] = 1'b1; bus.daddr[0] = 32'h300;
    exp_ack("inv_ack", 2'b10, 2'b10, 32'h0, 32'h300);
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge CLK);
      check("inv_ccwait", 64'(bus.ccwait), 64'h2);
      check("inv_ccinv", 64'(bus.ccinv), 64'h2);
      check("inv_snpaddr", 64'(bus.ccsnoopaddr[1]), 64'h300);
      check("inv_no_ram", 64'({bus.ramREN, bus.ramWEN}), 64'h0);
    end
    step(); bus.cctrans[1] = 1'b1;
    step(); bus.cctrans = 2'b00;

    // Instruction fetch through a slow RAM.
    step();
    bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h40; bus.ramstate = BUSY;
    exp_if("ifetch_slow", 1'b0, 32'h40, 32'hDEAD0040);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge CLK);
      check("ifetch_busy_ren", 64'({bus.ramREN, bus.ramaddr}), 64'h1_0000_0040);
      check("ifetch_busy_iwait", 64'(bus.iwait), 64'h3);
    end
    step(); bus.ramstate = ACCESS;
    step(); bus.iREN[0] = 1'b0;

    // Dcache request beats a concurrent fetch from the other core.
    step();
    bus.dWEN[1] = 1'b1; bus.daddr[1] = 32'h700; bus.dstore[1] = 32'h7;
    bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h80;
    exp_wb("d_over_i_w0", 1'b1, 32'h700, 32'h7);
    exp_wb("d_over_i_w1", 1'b1, 32'h704, 32'h77);
    exp_if("d_over_i_fetch", 1'b0, 32'h80, 32'hDEAD0080);
    step();
    step(); bus.daddr[1] = 32'h704; bus.dstore[1] = 32'h77;
    step(); bus.dWEN[1] = 1'b0;
    step();
    step(); bus.iREN[0] = 1'b0;

    // Leave the round-robin pointer at core1, then reset during LD2.
    both_wb(1'b1);
    step();
    bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h100;
    exp_ack("rst_rd_ack", 2'b10, 2'b00, 32'h0, 32'h100);
    exp_ld("rst_rd_w0", 1'b0, 32'h100, 32'hDEAD0100);
    step();
    step(); bus.cctrans[1] = 1'b1;
    step(); bus.cctrans[1] = 1'b0;
    step(); bus.daddr[0] = 32'h104; bus.ramstate = BUSY; RST = 1'b1;
    @(negedge CLK);
    check("ld2_ren_before_rst", 64'(bus.ramREN), 64'h1);
    step();
    RST = 1'b0; bus.dREN[0] = 1'b0; bus.ramstate = ACCESS;
    bus.iREN[1] = 1'b1; bus.iaddr[1] = 32'hC0;
    exp_if("post_rst_fetch", 1'b1, 32'hC0, 32'hDEAD00C0);
    @(negedge CLK);
    check("post_rst_dwait", 64'(bus.dwait), 64'h3);
    check("post_rst_iwait", 64'(bus.iwait), 64'h3);
    check("post_rst_ram", 64'({bus.ramREN, bus.ramWEN}), 64'h0);
    check("post_rst_cc", 64'({bus.ccwait, bus.ccinv}), 64'h0);
    step();
    step(); bus.iREN[1] = 1'b0;
    // Pointer must have been cleared: core1 wins the tie again.
    both_wb(1'b1);

    repeat (3) step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
